// File: rtl/serializer_pkg.sv
// Shared link definitions for the bit-stuffed serial link (transmit and receive ends).
// Holds the default stuffing run, the idle fill byte and the line FSM state encoding.
package serializer_pkg;

    localparam int         STUFF_RUN_DEFAULT = 5;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

    // Line FSM: either shifting a data/idle bit or emitting an inserted stuff 0.
    localparam logic [0:0] ST_DATA  = 1'b0;
    localparam logic [0:0] ST_STUFF = 1'b1;

    // Width of the consecutive-ones counter for a given stuffing run length.
    function automatic int ones_width(input int run);
        return $clog2(run + 1);
    endfunction

endpackage

// File: rtl/serializer.sv
// Transmit end of the bit-stuffed serial link: bytes in over valid/ready, MSB-first line out,
// a stuffed 0 after every STUFF_RUN line 1s, and IDLE_BYTE filled in whenever nothing is queued.
module serializer
    import serializer_pkg::*;
#(
    parameter int         STUFF_RUN = STUFF_RUN_DEFAULT,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_out,
    output logic       strobe,
    output logic       stuff_bit,
    output logic       underrun
);

    localparam int                ONES_W    = ones_width(STUFF_RUN);
    localparam logic [ONES_W-1:0] RUN_LIMIT = ONES_W'(STUFF_RUN);

    logic [0:0]        r_state;
    logic [7:0]        r_shreg;
    logic [2:0]        r_bit_idx;
    logic [ONES_W-1:0] r_ones;
    logic [7:0]        r_hold;
    logic              r_hold_full;
    logic              r_underrun;

    logic              w_line_bit;
    logic              w_byte_end;
    logic              w_accept;
    logic [ONES_W-1:0] w_ones_next;
    logic              w_run_hit;

    assign w_line_bit  = r_shreg[3'd7 - r_bit_idx];
    assign w_byte_end  = (r_state == ST_DATA) && (r_bit_idx == 3'd7);
    assign w_accept    = in_valid && !r_hold_full;
    assign w_ones_next = w_line_bit ? (r_ones + ONES_W'(1)) : '0;
    assign w_run_hit   = (w_ones_next == RUN_LIMIT);

    // Line-side state. The run counter deliberately ignores byte boundaries, so a stuff 0
    // may land between bit 0 of one byte and the MSB of the next.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_DATA;
            r_shreg    <= IDLE_BYTE;
            r_bit_idx  <= 3'd0;
            r_ones     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_DATA: begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (w_run_hit) begin
                        r_ones  <= '0;
                        r_state <= ST_STUFF;
                    end else begin
                        r_ones <= w_ones_next;
                    end
                    if (r_bit_idx == 3'd7) begin
                        if (r_hold_full) begin
                            r_shreg <= r_hold;
                        end else begin
                            r_shreg    <= IDLE_BYTE;
                            r_underrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_ones  <= '0;
                    r_state <= ST_DATA;
                end
            endcase
        end
    end

    // Holding register flag: drained on the byte-end load, refilled on accept. The two
    // never coincide because accept requires the register to be empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
        end else if (w_byte_end && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end
    end

    // NOTE: the hold data register has no reset; r_hold_full alone decides whether it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= in_data;
        end
    end

    assign data_out  = (r_state == ST_DATA) && w_line_bit;
    assign strobe    = w_byte_end;
    assign stuff_bit = (r_state == ST_STUFF);
    assign underrun  = r_underrun;
    assign in_ready  = !r_hold_full;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: hand-computed line bit patterns, flags and handshake per cycle.
module tb_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       data_out;
    logic       strobe;
    logic       stuff_bit;
    logic       underrun;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tx_q[$];

    serializer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .strobe    (strobe),
        .stuff_bit (stuff_bit),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One line cycle: offer the head of tx_q, advance past the edge, pop it if it was taken.
    task automatic tick();
        logic acc;
        in_valid = (tx_q.size() != 0);
        in_data  = in_valid ? tx_q[0] : 8'h00;
        acc      = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) void'(tx_q.pop_front());
        in_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/data_out"},  8'(data_out),  8'h00);
        check({tag, "/in_ready"},  8'(in_ready),  8'h01);
        check({tag, "/strobe"},    8'(strobe),    8'h00);
        check({tag, "/stuff_bit"}, 8'(stuff_bit), 8'h00);
        check({tag, "/underrun"},  8'(underrun),  8'h00);
    endtask

    // Expected patterns are right-aligned, first line cycle in the highest used bit.
    task automatic expect_line(input string tag, input int n, input logic [63:0] bits,
                               input logic [63:0] stf, input logic [63:0] stb,
                               input logic [63:0] und, input logic [63:0] rdy);
        for (int i = 0; i < n; i++) begin
            int b = n - 1 - i;
            string t = $sformatf("%s[%0d]", tag, i);
            check({t, "/data_out"},  8'(data_out),  8'(bits[b]));
            check({t, "/stuff_bit"}, 8'(stuff_bit), 8'(stf[b]));
            check({t, "/strobe"},    8'(strobe),    8'(stb[b]));
            check({t, "/underrun"},  8'(underrun),  8'(und[b]));
            check({t, "/in_ready"},  8'(in_ready),  8'(rdy[b]));
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        reset_n = 1'b1;

        // Idle line: zeros, strobe on every 8th cycle, underrun at each later byte start.
        expect_line("idle", 32, 64'h0, 64'h0,
                    32'b00000001_00000001_00000001_00000001,
                    32'b00000000_10000000_10000000_10000000,
                    32'hFFFF_FFFF);

        tx_q.push_back(8'hA5);
        expect_line("a5", 16, 16'b00000000_10100101, 64'h0,
                    16'b00000001_00000001,
                    16'b10000000_00000000,
                    16'b10000000_11111111);

        tx_q.push_back(8'hFF);
        tx_q.push_back(8'hFF);
        expect_line("ff_ff", 27,
                    27'b00000000_111110111_1101111101,
                    27'b00000000_000001000_0010000010,
                    27'b00000001_000000001_0000000001,
                    27'b10000000_000000000_0000000000,
                    27'b10000000_100000000_1111111111);

        tx_q.push_back(8'h0F);
        tx_q.push_back(8'hF0);
        expect_line("0f_f0", 25,
                    25'b00000000_00001111_101110000,
                    25'b00000000_00000000_010000000,
                    25'b00000001_00000001_000000001,
                    25'b10000000_00000000_000000000,
                    25'b10000000_10000000_111111111);

        tx_q.push_back(8'h81);
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'h7E);
        tx_q.push_back(8'h42);
        expect_line("four", 41,
                    41'b00000000_10000001_00111100_011111010_01000010,
                    41'b00000000_00000000_00000000_000000100_00000000,
                    41'b00000001_00000001_00000001_000000001_00000001,
                    41'b10000000_00000000_00000000_000000000_00000000,
                    41'b10000000_10000000_10000000_100000000_11111111);

        // Reach a stuff cycle with the hold register full, then pulse reset inside it.
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'hAA);
        expect_line("pre_rst", 13, 13'b00000000_11111, 64'h0,
                    13'b00000001_00000,
                    13'b10000000_00000,
                    13'b10000000_10000);
        check("stuff_before_rst/stuff_bit", 8'(stuff_bit), 8'h01);
        check("stuff_before_rst/data_out",  8'(data_out),  8'h00);
        check("stuff_before_rst/in_ready",  8'(in_ready),  8'h00);
        reset_n = 1'b0;
        #1;
        check_reset("rst_in_stuff");
        #2;
        reset_n = 1'b1;

        // Both the partial 0xFF and the held 0xAA must be gone: pure idle with underrun.
        expect_line("post_rst", 16, 64'h0, 64'h0,
                    16'b00000001_00000001,
                    16'b00000000_10000000,
                    16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
